note_tone_gen: RTL and testbench

Audio back end for the song player. It consumes the 19-bit `out_note` half-period word and synthesises a square-wave tone with a linear attack/release envelope. The tone is delivered as 32-bit signed samples to the audio codec output FIFO at a fixed sample rate, using a write/allowed handshake. It sits between `song_player` and the board audio core.

---
 rtl/note_pkg.sv | 32 +++
 rtl/sample_tick_gen.sv | 30 +++
 rtl/note_tone_gen.sv | 143 ++++++++++++++
 tb/tb_note_tone_gen.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/note_pkg.sv
// Shared constants and output-FSM state encoding for the note tone generator.
// No logic; no latency; no backpressure.
// Imported by note_tone_gen.
package note_pkg;

    localparam int NOTE_W         = 19;
    localparam int SAMPLE_DIV_DEF = 1042;
    localparam int AMP_SHIFT_DEF  = 16;
    localparam int LEVEL_W        = 8;
    localparam logic [LEVEL_W-1:0] LEVEL_MAX = 8'd255;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        WRITE = 2'd2
    } out_state_e;

    function automatic logic [LEVEL_W-1:0] level_step(
        input logic [LEVEL_W-1:0] lvl,
        input logic               up
    );
        logic [LEVEL_W-1:0] r;
        r = lvl;
        if (up) begin
            if (lvl != LEVEL_MAX) r = lvl + 8'd1;
        end else begin
            if (lvl != '0) r = lvl - 8'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Free-running divider producing a one-cycle tick every DIV clocks.
// Tick asserts combinationally in the cycle the count equals DIV-1.
// No backpressure: the tick never stalls.
module sample_tick_gen #(
    parameter int DIV = 1042
) (
    input  logic clk_i,
    input  logic reset_i,
    output logic tick_o
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) cnt_d = '0;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign tick_o = (cnt_q == CNT_LAST);

endmodule

// File: rtl/note_tone_gen.sv
// Square-wave tone with linear attack/release envelope, one sample per tick.
// Sample registered one cycle after tick; earliest write strobe two cycles after.
// Codec backpressure via audio_out_allowed; a sample replaced while waiting flags overrun.
module note_tone_gen
    import note_pkg::*;
#(
    parameter int SAMPLE_DIV = SAMPLE_DIV_DEF,
    parameter int AMP_SHIFT  = AMP_SHIFT_DEF
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic [NOTE_W-1:0] out_note,
    input  logic              enable,
    input  logic              audio_out_allowed,
    output logic              write_audio_out,
    output logic [31:0]       left_channel_audio_out,
    output logic [31:0]       right_channel_audio_out,
    output logic              tone_active,
    output logic              overrun
);

    logic tick;

    sample_tick_gen #(
        .DIV (SAMPLE_DIV)
    ) u_tick (
        .clk_i   (CLOCK_50),
        .reset_i (reset),
        .tick_o  (tick)
    );

    // Note latch and phase counter
    logic [NOTE_W-1:0] cur_note_q, cur_note_d;
    logic [NOTE_W-1:0] phase_q, phase_d;
    logic              polarity_q, polarity_d;

    always_comb begin
        cur_note_d = cur_note_q;
        phase_d    = phase_q;
        polarity_d = polarity_q;
        if (out_note != cur_note_q) begin
            // New note restarts the half-period but keeps the current polarity.
            cur_note_d = out_note;
            phase_d    = '0;
        end else if (cur_note_q == '0) begin
            phase_d    = '0;
            polarity_d = 1'b0;
        end else if (phase_q == cur_note_q - NOTE_W'(1)) begin
            phase_d    = '0;
            polarity_d = ~polarity_q;
        end else begin
            phase_d    = phase_q + NOTE_W'(1);
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            cur_note_q <= '0;
            phase_q    <= '0;
            polarity_q <= 1'b0;
        end else begin
            cur_note_q <= cur_note_d;
            phase_q    <= phase_d;
            polarity_q <= polarity_d;
        end
    end

    // Envelope and sample
    logic [LEVEL_W-1:0] level_q, level_d;
    logic [31:0]        sample_q, sample_d;
    logic [31:0]        magnitude;
    logic               tone_active_q, tone_active_d;

    always_comb begin
        level_d       = level_q;
        sample_d      = sample_q;
        tone_active_d = tone_active_q;
        magnitude     = '0;
        if (tick) begin
            level_d       = level_step(level_q, enable && (cur_note_q != '0));
            magnitude     = 32'(level_d) << AMP_SHIFT;
            sample_d      = polarity_q ? magnitude : (~magnitude + 32'd1);
            tone_active_d = (level_d != '0);
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            level_q       <= '0;
            sample_q      <= '0;
            tone_active_q <= 1'b0;
        end else begin
            level_q       <= level_d;
            sample_q      <= sample_d;
            tone_active_q <= tone_active_d;
        end
    end

    // Output FSM
    out_state_e state_q, state_d;
    logic       overrun_q, overrun_d;

    always_comb begin
        state_d   = state_q;
        overrun_d = overrun_q;
        unique case (state_q)
            IDLE: begin
                if (tick) state_d = WAIT;
            end
            WAIT: begin
                // A tick here overwrites the sample that never made it out.
                if (tick) begin
                    overrun_d = 1'b1;
                end else if (audio_out_allowed) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                state_d = tick ? WAIT : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q   <= IDLE;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            overrun_q <= overrun_d;
        end
    end

    assign write_audio_out         = (state_q == WRITE);
    assign left_channel_audio_out  = sample_q;
    assign right_channel_audio_out = sample_q;
    assign tone_active             = tone_active_q;
    assign overrun                 = overrun_q;

endmodule

// File: tb/tb_note_tone_gen.sv
// Directed bench for note_tone_gen with an 8-cycle sample period.
// Edge e counts clock edges since reset release; ticks fall in the cycle after edge 8m+7.
module tb_note_tone_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic [18:0] out_note;
    logic        enable;
    logic        allowed;
    logic        wr;
    logic [31:0] left_o, right_o;
    logic        tone_active;
    logic        overrun;

    int checks = 0;
    int errors = 0;
    int e = 0;

    always #5 clk = ~clk;

    note_tone_gen #(
        .SAMPLE_DIV (8),
        .AMP_SHIFT  (16)
    ) dut (
        .CLOCK_50                (clk),
        .reset                   (reset),
        .out_note                (out_note),
        .enable                  (enable),
        .audio_out_allowed       (allowed),
        .write_audio_out         (wr),
        .left_channel_audio_out  (left_o),
        .right_channel_audio_out (right_o),
        .tone_active             (tone_active),
        .overrun                 (overrun)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s (edge %0d): observed %h expected %h", tag, e, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        e++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) cyc();
        reset = 1'b0;
        e = 0;
    endtask

    // Polarity after edge n for a note of 5 loaded at edge 1 after reset.
    function automatic logic pol5(input int n);
        return ((n - 1) / 5) % 2 == 1;
    endfunction

    task automatic chk_sample(input string tag, input logic [31:0] exp);
        chk({tag, "_l"}, left_o, exp);
        chk({tag, "_r"}, right_o, exp);
    endtask

    initial begin
        out_note = '0;
        enable   = 1'b0;
        allowed  = 1'b0;
        reset    = 1'b1;

        // Reset state and silence with out_note = 0
        do_reset();
        chk("rst_wr", 32'(wr), 32'd0);
        chk_sample("rst_smp", 32'h0);
        chk("rst_active", 32'(tone_active), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        for (int i = 0; i < 40; i++) begin
            cyc();
            chk("idle_wr", 32'(wr), 32'd0);
            chk("idle_active", 32'(tone_active), 32'd0);
            chk("idle_smp", left_o, 32'h0);
        end

        // Tone at half-period 5 with attack, codec always ready
        out_note = 19'd5;
        enable   = 1'b1;
        allowed  = 1'b1;
        do_reset();
        for (int i = 0; i < 26; i++) begin
            cyc();
            chk("t2_pol", 32'(dut.polarity_q), 32'(pol5(e)));
            chk("t2_wr", 32'(wr), 32'((e % 8 == 1) && (e >= 9)));
            if (e == 9)  chk_sample("t2_s1", 32'h0001_0000);
            if (e == 17) chk_sample("t2_s2", 32'hFFFE_0000);
            if (e == 25) chk_sample("t2_s3", 32'hFFFD_0000);
            if (e == 8)  chk("t2_active", 32'(tone_active), 32'd1);
        end

        // Codec stalled across two ticks
        allowed = 1'b0;
        while (e < 40) begin
            cyc();
            chk("t3_wr", 32'(wr), 32'd0);
            chk("t3_overrun", 32'(overrun), 32'(e >= 40));
            if (e == 32) chk_sample("t3_s4", 32'hFFFC_0000);
        end
        chk_sample("t3_s5", 32'h0005_0000);
        allowed = 1'b1;
        while (e < 47) begin
            cyc();
            chk("t3_one_wr", 32'(wr), 32'(e == 41));
            if (e == 41) chk_sample("t3_wr_smp", 32'h0005_0000);
            chk("t3_sticky", 32'(overrun), 32'd1);
        end

        // Note 5 -> 3 two cycles into a half-period (last toggle at edge 46)
        cyc();
        chk("t4_phase", dut.phase_q, 32'd2);
        out_note = 19'd3;
        while (e < 57) begin
            cyc();
            chk("t4_pol", 32'(dut.polarity_q), 32'((e <= 51) || (e >= 55)));
        end

        // Release: level 4 then enable = 0
        out_note = 19'd5;
        enable   = 1'b1;
        allowed  = 1'b1;
        do_reset();
        while (e < 32) cyc();
        enable = 1'b0;
        while (e < 73) begin
            cyc();
            chk("t5_wr", 32'(wr), 32'(e % 8 == 1));
            if (e == 41) chk_sample("t5_l3", 32'h0003_0000);
            if (e == 49) chk_sample("t5_l2", 32'h0002_0000);
            if (e == 57) chk_sample("t5_l1", 32'hFFFF_0000);
            if (e == 65) chk_sample("t5_l0", 32'h0000_0000);
            if (e == 73) chk_sample("t5_l0b", 32'h0000_0000);
            if (e == 63) chk("t5_active_hi", 32'(tone_active), 32'd1);
            if (e == 64) chk("t5_active_lo", 32'(tone_active), 32'd0);
        end

        // Reset while waiting on the codec
        enable  = 1'b1;
        allowed = 1'b0;
        while (e < 89) begin
            cyc();
            chk("t6_wr", 32'(wr), 32'd0);
            if (e == 80) chk_sample("t6_s1", 32'h0001_0000);
        end
        chk("t6_overrun_pre", 32'(overrun), 32'd1);
        chk_sample("t6_s2", 32'h0002_0000);
        allowed = 1'b1;
        reset   = 1'b1;
        cyc();
        chk("t6_rst_wr", 32'(wr), 32'd0);
        chk("t6_rst_overrun", 32'(overrun), 32'd0);
        chk_sample("t6_rst_smp", 32'h0);
        chk("t6_rst_active", 32'(tone_active), 32'd0);
        reset = 1'b0;
        e = 0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            chk("t6_no_wr", 32'(wr), 32'd0);
        end
        cyc();
        chk("t6_first_wr", 32'(wr), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
